// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the bus-attached UART transmitter.
package uart_tx_pkg;

    // Transmit FSM states; IDLE is the only non-busy state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

    // Register indices, decoded from device_addr_i[3:2].
    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CTRL   = 2'd2;
    localparam logic [1:0] UART_LEVEL  = 2'd3;

    // STATUS register bit positions.
    localparam int STATUS_EMPTY    = 0;
    localparam int STATUS_FULL     = 1;
    localparam int STATUS_BUSY     = 2;
    localparam int STATUS_OVERFLOW = 3;

    // CTRL register bit positions.
    localparam int CTRL_IRQ_EN = 0;

    // Packs the STATUS word in its register layout.
    function automatic logic [31:0] status_word(input logic overflow, input logic busy,
                                                input logic full, input logic empty);
        return {28'b0, overflow, busy, full, empty};
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// First-word-fall-through synchronous FIFO; pushes into a full FIFO and
// pops from an empty one are ignored.
module fifo_sync #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    output logic                     full,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Fullness comes from the registered count, so a same-cycle pop never
    // makes room for a push.
    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset because count guards every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Bus-attached 8N1 UART transmitter: register block, TX FIFO and a serialiser
// FSM whose line output is registered from the next state.
module uart_tx_dev
    import uart_tx_pkg::*;
#(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int FifoDepth      = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    output logic        uart_tx_o,
    output logic        uart_irq_o
);
    localparam int ClkPerBit = ClockFrequency / BaudRate;
    localparam int BaudW     = $clog2(ClkPerBit);
    localparam int CntW      = $clog2(FifoDepth) + 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClkPerBit - 1);

    // Bus decode
    logic [1:0]  reg_idx;
    logic        wr_lo;
    logic        push;
    logic        ovf_clr;
    logic        ctrl_wr;
    logic [31:0] rdata_d;

    // Register state
    logic overflow_q;
    logic irq_en_q;

    // FIFO interface
    logic            pop;
    logic [7:0]      fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;

    // Serialiser state
    uart_tx_state_e   state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [BaudW-1:0] baud_cnt_q, baud_cnt_d;
    logic             baud_end;
    logic             tx_d;
    logic             busy;

    // Bus bits that the register map never looks at.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{device_addr_i[31:4], device_addr_i[1:0],
                               device_be_i[3:1], device_wdata_i[31:8]};

    assign reg_idx = device_addr_i[3:2];
    assign wr_lo   = device_req_i & device_we_i & device_be_i[0];
    assign push    = wr_lo & (reg_idx == UART_TXDATA);
    assign ovf_clr = wr_lo & (reg_idx == UART_STATUS) & device_wdata_i[STATUS_OVERFLOW];
    assign ctrl_wr = wr_lo & (reg_idx == UART_CTRL);

    assign busy     = (state_q != IDLE);
    assign baud_end = (baud_cnt_q == BaudLast);

    fifo_sync #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .wdata (device_wdata_i[7:0]),
        .full  (fifo_full),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Overflow flag (set beats clear) and the interrupt enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            if (push && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
            if (ctrl_wr) begin
                irq_en_q <= device_wdata_i[CTRL_IRQ_EN];
            end
        end
    end

    // Read mux from this cycle's address and state; writes return zero.
    always_comb begin
        rdata_d = '0;
        if (device_req_i && !device_we_i) begin
            case (reg_idx)
                UART_STATUS: rdata_d = status_word(overflow_q, busy, fifo_full, fifo_empty);
                UART_CTRL:   rdata_d = {31'b0, irq_en_q};
                UART_LEVEL:  rdata_d = 32'(fifo_count);
                default:     rdata_d = '0;
            endcase
        end
    end

    // Bus response and interrupt are registered one cycle behind their sources.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            device_rvalid_o <= 1'b0;
            device_rdata_o  <= '0;
            uart_irq_o      <= 1'b0;
        end else begin
            device_rvalid_o <= device_req_i;
            device_rdata_o  <= rdata_d;
            uart_irq_o      <= irq_en_q & fifo_empty & ~busy;
        end
    end

    // Serialiser next-state logic; the line level is derived from the next
    // state so the registered output lines up with the state it belongs to.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        pop        = 1'b0;
        tx_d       = 1'b1;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = fifo_rdata;
                    bit_cnt_d  = '0;
                    baud_cnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Serialiser registers; reset drops any frame in flight and idles the line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            uart_tx_o  <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            uart_tx_o  <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev: the serial line is recorded one sample
// per cycle and decoded as 8N1 frames, then compared with the bytes the bench
// expects to have been accepted by the register interface.
module tb_uart_tx_dev;
    localparam int CPB   = 4;          // 1 MHz / 250 kBd
    localparam int FRAME = 10 * CPB;   // start + 8 data + stop

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be    = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic       rec_en = 1'b0;
    logic       trace[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         gap_q[$];
    int         shape_err   = 0;
    int         first_start = -1;

    uart_tx_dev #(
        .ClockFrequency (1_000_000),
        .BaudRate       (250_000),
        .FifoDepth      (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .device_req_i    (req),
        .device_addr_i   (addr),
        .device_we_i     (we),
        .device_be_i     (be),
        .device_wdata_i  (wdata),
        .device_rvalid_o (rvalid),
        .device_rdata_o  (rdata),
        .uart_tx_o       (tx),
        .uart_irq_o      (irq)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Line recorder: one sample per cycle, taken mid-cycle.
    always @(negedge clk) begin
        if (rec_en) trace.push_back(tx);
    end

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget, got running, need finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle bus write; returns 1 time unit after the accepting edge.
    task automatic bus_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = 1'b1; addr = {28'h0, idx, 2'b00}; wdata = d; be = b;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0; wdata = '0; be = '0;
    endtask

    // One-cycle bus read; response sampled after the following edge.
    task automatic bus_read(input logic [1:0] idx, output logic v, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = {28'h0, idx, 2'b00}; be = 4'hF;
        @(posedge clk);
        #1;
        req = 1'b0; be = '0;
        v = rvalid;
        d = rdata;
    endtask

    // Turn the recorded line into bytes, inter-frame idle gaps and shape errors.
    task automatic decode_trace();
        int i;
        int last_end;
        logic [7:0] b;
        got_q.delete();
        gap_q.delete();
        shape_err   = 0;
        first_start = -1;
        last_end    = -1;
        i           = 0;
        b           = '0;
        while (i < trace.size()) begin
            if (trace[i] === 1'b1) begin
                i++;
            end else if (i + FRAME > trace.size()) begin
                shape_err++;
                i = trace.size();
            end else begin
                for (int s = 0; s < 10; s++)
                    for (int k = 1; k < CPB; k++)
                        if (trace[i + s*CPB + k] !== trace[i + s*CPB]) shape_err++;
                if (trace[i + 9*CPB] !== 1'b1) shape_err++;
                for (int j = 0; j < 8; j++) b[j] = trace[i + (j+1)*CPB];
                if (first_start < 0) first_start = i;
                if (last_end >= 0) gap_q.push_back(i - last_end);
                got_q.push_back(b);
                last_end = i + FRAME;
                i = last_end;
            end
        end
    endtask

    task automatic test_reset();
        logic v;
        logic [31:0] d;
        rst = 1'b1;
        step(2);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b need 1", tx); end
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b need 0", rvalid); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b need 0", irq); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h need 0", rdata); end
        rst = 1'b0;
        bus_read(2'd1, v, d);
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL reset_rvalid_read: got %b need 1", v); end
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h need 1", d); end
        bus_read(2'd3, v, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_level: got %h need 0", d); end
        bus_read(2'd2, v, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h need 0", d); end
        bus_read(2'd0, v, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_txdata_read: got %h need 0", d); end
        step(1);
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_drop: got %b need 0", rvalid); end
    endtask

    task automatic test_single_frame();
        logic v;
        logic [31:0] d;
        trace.delete();
        exp_q.delete();
        exp_q.push_back(8'h55);
        bus_write(2'd0, 32'h55, 4'h1);       // cycle N; now in N+1
        rec_en = 1'b1;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL frame_n1_tx: got %b need 1", tx); end
        step(1);                              // N+2
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL frame_n2_tx: got %b need 0", tx); end
        step(40);                             // N+42
        rec_en = 1'b0;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL frame_n42_tx: got %b need 1", tx); end
        bus_read(2'd1, v, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL frame_n42_status: got %h need 1", d); end
        decode_trace();
        n_checks++; if (first_start !== 1) begin n_fail++; $display("FAIL frame_start_pos: got %0d need 1", first_start); end
        n_checks++; if (shape_err !== 0) begin n_fail++; $display("FAIL frame_shape: got %0d need 0", shape_err); end
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL frame_count: got %0d need %0d", got_q.size(), exp_q.size()); end
        else if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL frame_byte: got %h need %h", got_q[0], exp_q[0]); end
    endtask

    task automatic test_overflow();
        logic v;
        logic [31:0] d;
        int bad_gaps;
        trace.delete();
        exp_q.delete();
        rec_en = 1'b1;
        // First byte leaves at once, four fill the FIFO, the sixth is dropped.
        for (int i = 1; i <= 6; i++) begin
            bus_write(2'd0, 32'(i), 4'h1);
            if (i <= 5) exp_q.push_back(8'(i));
        end
        bus_read(2'd3, v, d);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL ovf_level: got %h need 4", d); end
        bus_read(2'd1, v, d);
        n_checks++; if (d !== 32'hE) begin n_fail++; $display("FAIL ovf_status_set: got %h need e", d); end
        bus_write(2'd1, 32'h8, 4'h0);         // be[0]=0: no effect
        bus_read(2'd1, v, d);
        n_checks++; if (d !== 32'hE) begin n_fail++; $display("FAIL ovf_clear_no_be: got %h need e", d); end
        bus_write(2'd1, 32'h8, 4'h1);
        bus_read(2'd1, v, d);
        n_checks++; if (d !== 32'h6) begin n_fail++; $display("FAIL ovf_cleared: got %h need 6", d); end
        bus_write(2'd0, 32'h77, 4'h1);        // FIFO still full: dropped again
        bus_read(2'd1, v, d);
        n_checks++; if (d !== 32'hE) begin n_fail++; $display("FAIL ovf_reset: got %h need e", d); end
        step(5 * (FRAME + 1) + 20);
        rec_en = 1'b0;
        decode_trace();
        n_checks++; if (shape_err !== 0) begin n_fail++; $display("FAIL ovf_shape: got %0d need 0", shape_err); end
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovf_frames: got %0d need %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        bad_gaps = 0;
        foreach (gap_q[i]) if (gap_q[i] != 1) bad_gaps++;
        n_checks++; if (bad_gaps !== 0) begin n_fail++; $display("FAIL ovf_gaps: got %0d bad gaps need 0", bad_gaps); end
        bus_read(2'd1, v, d);
        n_checks++; if (d !== 32'h9) begin n_fail++; $display("FAIL ovf_drained: got %h need 9", d); end
        bus_write(2'd1, 32'h8, 4'h1);
        bus_read(2'd1, v, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL ovf_final_clear: got %h need 1", d); end
    endtask

    task automatic test_irq();
        logic v;
        logic [31:0] d;
        int hi;
        bus_write(2'd2, 32'hFFFF_FFFF, 4'hF);
        bus_read(2'd2, v, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL irq_ctrl_read: got %h need 1", d); end
        step(1);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_idle_en: got %b need 1", irq); end
        bus_write(2'd0, 32'hA5, 4'h1);       // cycle N; now N+1
        step(1);                              // N+2
        hi = 0;
        for (int c = 0; c < 41; c++) begin   // N+2 .. N+42
            if (irq !== 1'b0) hi++;
            step(1);
        end
        n_checks++; if (hi !== 0) begin n_fail++; $display("FAIL irq_busy: got %0d high cycles need 0", hi); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b need 1", irq); end
        bus_write(2'd2, 32'h0, 4'h1);        // cycle M; now M+1
        step(1);                              // M+2
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b need 0", irq); end
    endtask

    task automatic test_random();
        int k;
        int bad_gaps;
        logic [7:0] b;
        logic [3:0] bsel;
        logic v;
        logic [31:0] d;
        for (int it = 0; it < 4; it++) begin
            trace.delete();
            exp_q.delete();
            k = $urandom_range(1, 4);
            rec_en = 1'b1;
            for (int i = 0; i < k; i++) begin
                b    = 8'($urandom_range(0, 255));
                bsel = ($urandom_range(0, 3) == 0) ? 4'hE : 4'hF;
                bus_write(2'd0, {24'h0, b}, bsel);
                if (bsel[0]) exp_q.push_back(b);
            end
            step(k * (FRAME + 1) + k + 10);
            rec_en = 1'b0;
            decode_trace();
            n_checks++; if (shape_err !== 0) begin n_fail++; $display("FAIL rnd%0d_shape: got %0d need 0", it, shape_err); end
            n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_frames: got %0d need %0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_byte%0d: got %h need %h", it, i, got_q[i], exp_q[i]); end
            end
            bad_gaps = 0;
            foreach (gap_q[i]) if (gap_q[i] != 1) bad_gaps++;
            n_checks++; if (bad_gaps !== 0) begin n_fail++; $display("FAIL rnd%0d_gaps: got %0d bad gaps need 0", it, bad_gaps); end
            bus_read(2'd3, v, d);
            n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rnd%0d_level: got %h need 0", it, d); end
            step($urandom_range(0, 5));
        end
    endtask

    task automatic test_reset_midframe();
        logic v;
        logic [31:0] d;
        int zeros;
        bus_write(2'd0, 32'hFF, 4'h1);       // cycle N
        bus_write(2'd0, 32'h11, 4'h1);
        bus_write(2'd0, 32'h22, 4'h1);       // now N+3
        bus_read(2'd3, v, d);                 // read in N+3
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL midrst_level_before: got %h need 2", d); end
        step(6);                              // N+10, inside DATA
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b need 1", tx); end
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid: got %b need 0", rvalid); end
        trace.delete();
        rec_en = 1'b1;
        step(100);
        rec_en = 1'b0;
        zeros = 0;
        foreach (trace[i]) if (trace[i] !== 1'b1) zeros++;
        n_checks++; if (zeros !== 0) begin n_fail++; $display("FAIL midrst_line_quiet: got %0d low cycles need 0", zeros); end
        bus_read(2'd3, v, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_level_after: got %h need 0", d); end
        bus_read(2'd1, v, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL midrst_status: got %h need 1", d); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_irq();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
